// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: FSM states, opcodes/functs, ALU control.
// Optional performance counters in the core are enabled by defining MULTICYCLE_MIPS_PERF_EN.
package mips_pkg;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_ctl_e;

  function automatic alu_ctl_e funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// Register file: REG_NUM x DATA_W, two asynchronous reads, one synchronous write.
// r0 always reads zero and silently drops writes.
module mips_regfile #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32,
  localparam int RW     = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RW-1:0]     raddr1,
  input  logic [RW-1:0]     raddr2,
  input  logic              we,
  input  logic [RW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [REG_NUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/multicycle_mips.sv
// Multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB over one shared ALU, stalls in MEM on mem_ready.
// Define MULTICYCLE_MIPS_PERF_EN to add the cycle_cnt/instr_cnt counter outputs.
module multicycle_mips
  import mips_pkg::*;
#(
  parameter int               DATA_W   = 32,
  parameter int               REG_NUM  = 32,
  parameter int               DMEM_AW  = 7,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [DATA_W-1:0]  IR_addr,
  input  logic [31:0]        IR,
  input  logic [DATA_W-1:0]  ReadDataMem,
  input  logic               mem_ready,
  output logic               CEN,
  output logic               WEN,
  output logic               OEN,
  output logic [DMEM_AW-1:0] A,
  output logic [DATA_W-1:0]  ReadData2,
  output logic [DATA_W-1:0]  RF_writedata,
  output logic               retire
`ifdef MULTICYCLE_MIPS_PERF_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instr_cnt
`endif
);

  localparam int RW = $clog2(REG_NUM);
  localparam logic [4:0] R31 = 5'd31;

  logic [2:0]        state;
  logic [DATA_W-1:0] pc, a_q, b_q, alu_out, mdr;
  logic [31:0]       instr;

  logic [5:0]        op, funct;
  logic [DATA_W-1:0] sext_imm;
  logic              is_r_alu, is_jr, is_addi, is_lw, is_sw, is_beq, is_j, is_jal, is_valid;

  assign op       = instr[31:26];
  assign funct    = instr[5:0];
  assign sext_imm = {{(DATA_W-16){instr[15]}}, instr[15:0]};

  assign is_r_alu = (op == OP_RTYPE) &&
                    (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
  assign is_jr    = (op == OP_RTYPE) && (funct == FN_JR);
  assign is_addi  = (op == OP_ADDI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);
  assign is_valid = is_r_alu | is_jr | is_addi | is_lw | is_sw | is_beq | is_j | is_jal;

  // Register file; indices wrap modulo REG_NUM by taking the low RW bits.
  logic              rf_we;
  logic [RW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata, rf_rd1, rf_rd2;

  mips_regfile #(.DATA_W(DATA_W), .REG_NUM(REG_NUM)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (instr[20+RW:21]),
    .raddr2 (instr[15+RW:16]),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

  // One ALU: PC+4 in FETCH, branch target in DECODE, datapath/address in EXEC.
  logic [DATA_W-1:0] alu_a, alu_b, alu_res;
  alu_ctl_e          alu_ctl;

  always_comb begin
    alu_a   = pc;
    alu_b   = DATA_W'(4);
    alu_ctl = ALU_ADD;
    if (state == S_DECODE) begin
      alu_b = sext_imm << 2;
    end else if (state == S_EXEC) begin
      alu_a   = a_q;
      alu_b   = is_r_alu ? b_q : sext_imm;
      alu_ctl = is_r_alu ? funct_to_alu(funct) : ALU_ADD;
    end
  end

  always_comb begin
    case (alu_ctl)
      ALU_SUB: alu_res = alu_a - alu_b;
      ALU_AND: alu_res = alu_a & alu_b;
      ALU_OR:  alu_res = alu_a | alu_b;
      ALU_SLT: alu_res = ($signed(alu_a) < $signed(alu_b)) ? DATA_W'(1) : '0;
      default: alu_res = alu_a + alu_b;
    endcase
  end

  // jal links in EXEC (PC already holds PC+4); all other writes happen in WB.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (state == S_EXEC && is_jal) begin
      rf_we    = 1'b1;
      rf_waddr = R31[RW-1:0];
      rf_wdata = pc;
    end else if (state == S_WB) begin
      rf_we    = 1'b1;
      rf_waddr = is_r_alu ? instr[10+RW:11] : instr[15+RW:16];
      rf_wdata = is_lw ? mdr : alu_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      instr        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      alu_out      <= '0;
      mdr          <= '0;
      RF_writedata <= '0;
    end else begin
      if (rf_we) RF_writedata <= rf_wdata;
      case (state)
        S_FETCH: begin
          instr <= IR;
          pc    <= alu_res;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a_q     <= rf_rd1;
          b_q     <= rf_rd2;
          alu_out <= alu_res;
          state   <= is_valid ? S_EXEC : S_FETCH;
        end
        S_EXEC: begin
          if (is_r_alu || is_addi) begin
            alu_out <= alu_res;
            state   <= S_WB;
          end else if (is_lw || is_sw) begin
            alu_out <= alu_res;
            state   <= S_MEM;
          end else begin
            if (is_beq && (a_q == b_q)) pc <= alu_out;
            if (is_j || is_jal)         pc <= {pc[DATA_W-1:28], instr[25:0], 2'b00};
            if (is_jr)                  pc <= a_q;
            state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (is_lw) begin
              mdr   <= ReadDataMem;
              state <= S_WB;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  assign IR_addr   = pc;
  assign CEN       = (state != S_MEM);
  assign WEN       = !((state == S_MEM) && is_sw);
  assign OEN       = 1'b0;
  assign A         = alu_out[DMEM_AW+1:2];
  assign ReadData2 = b_q;
  assign retire    = ((state == S_DECODE) && !is_valid) ||
                     ((state == S_EXEC) && (is_beq || is_j || is_jal || is_jr)) ||
                     ((state == S_MEM) && mem_ready && is_sw) ||
                     (state == S_WB);

`ifdef MULTICYCLE_MIPS_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_mips.sv
// Directed bench for multicycle_mips: instruction ROM and data SRAM models with programmable wait states.
module tb_multicycle_mips;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] IR_addr, IR, ReadDataMem, ReadData2, RF_writedata;
  logic        mem_ready, CEN, WEN, OEN, retire;
  logic [6:0]  A;
`ifdef MULTICYCLE_MIPS_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  logic [31:0] imem [0:127];
  logic [31:0] dmem [0:127];
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  multicycle_mips dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IR_addr      (IR_addr),
    .IR           (IR),
    .ReadDataMem  (ReadDataMem),
    .mem_ready    (mem_ready),
    .CEN          (CEN),
    .WEN          (WEN),
    .OEN          (OEN),
    .A            (A),
    .ReadData2    (ReadData2),
    .RF_writedata (RF_writedata),
    .retire       (retire)
`ifdef MULTICYCLE_MIPS_PERF_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instr_cnt    (instr_cnt)
`endif
  );

  // Memory models: ROM is combinational, SRAM answers after wait_cfg cycles in MEM.
  assign IR          = imem[IR_addr[8:2]];
  assign ReadDataMem = dmem[A];
  assign mem_ready   = !CEN && (wait_cnt >= wait_cfg);

  always @(posedge clk) begin
    wait_cnt <= !CEN ? wait_cnt + 1 : 0;
    if (rst_n && !CEN && !WEN && mem_ready) dmem[A] <= ReadData2;
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    wait_cfg = 0;
    for (int i = 0; i < 128; i++) begin
      imem[i] = 32'h0;
      dmem[i] = 32'h0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Counts cycles from the current one up to the retire cycle; stops at 40.
  task automatic wait_retire(output int cycles);
    cycles = 1;
    while (retire !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    do_reset();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    n_checks++; if (IR_addr !== 32'h0) $display("FAIL reset_pc: IR_addr=%h expected 0", IR_addr); else n_pass++;
    n_checks++; if ({CEN, WEN, OEN, retire} !== 4'b1100) $display("FAIL reset_ctl: CEN/WEN/OEN/retire=%b expected 1100", {CEN, WEN, OEN, retire}); else n_pass++;
    n_checks++; if (A !== 7'h0 || ReadData2 !== 32'h0 || RF_writedata !== 32'h0) $display("FAIL reset_data: A=%h RD2=%h WD=%h expected 0", A, ReadData2, RF_writedata); else n_pass++;
`ifdef MULTICYCLE_MIPS_PERF_EN
    n_checks++; if (cycle_cnt !== 32'h0 || instr_cnt !== 32'h0) $display("FAIL reset_perf: cyc=%0d ins=%0d expected 0", cycle_cnt, instr_cnt); else n_pass++;
`endif
    step();
    n_checks++; if (IR_addr !== 32'h4) $display("FAIL first_fetch_pc: IR_addr=%h expected 4", IR_addr); else n_pass++;
    wait_retire(cyc);
    n_checks++; if (cyc + 1 !== 4) $display("FAIL addi_latency: retire cycle=%0d expected 4", cyc + 1); else n_pass++;
    step();
    n_checks++; if (RF_writedata !== 32'd5) $display("FAIL addi_wd: RF_writedata=%h expected 5", RF_writedata); else n_pass++;
`ifdef MULTICYCLE_MIPS_PERF_EN
    n_checks++; if (cycle_cnt !== 32'd4 || instr_cnt !== 32'd1) $display("FAIL perf_cnt: cyc=%0d ins=%0d expected 4/1", cycle_cnt, instr_cnt); else n_pass++;
`endif
  endtask

  task automatic test_load_wait();
    do_reset();
    wait_cfg = 2;
    dmem[3] = 32'hDEADBEEF;
    imem[0] = enc_i(6'h23, 5'd0, 5'd2, 16'd12);
    imem[1] = enc_i(6'h2B, 5'd0, 5'd2, 16'd16);
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (CEN !== 1'b0 || WEN !== 1'b1 || A !== 7'd3 || retire !== 1'b0) $display("FAIL lw_mem_hold%0d: CEN=%b WEN=%b A=%h retire=%b expected 0 1 03 0", k, CEN, WEN, A, retire); else n_pass++;
      step();
    end
    n_checks++; if (retire !== 1'b1 || CEN !== 1'b1) $display("FAIL lw_retire_c7: retire=%b CEN=%b expected 1 1", retire, CEN); else n_pass++;
    step();
    n_checks++; if (RF_writedata !== 32'hDEADBEEF) $display("FAIL lw_wd: RF_writedata=%h expected deadbeef", RF_writedata); else n_pass++;
    repeat (6) step();
    n_checks++; if (dmem[4] !== 32'hDEADBEEF) $display("FAIL lw_r2_stored: mem[4]=%h expected deadbeef", dmem[4]); else n_pass++;
  endtask

  task automatic test_store();
    int cyc;
    do_reset();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
    wait_retire(cyc);
    repeat (4) step();
    n_checks++; if (CEN !== 1'b0 || WEN !== 1'b0 || A !== 7'd2 || ReadData2 !== 32'd5) $display("FAIL sw_mem: CEN=%b WEN=%b A=%h RD2=%h expected 0 0 02 5", CEN, WEN, A, ReadData2); else n_pass++;
    n_checks++; if (retire !== 1'b1) $display("FAIL sw_latency: retire=%b expected 1 in cycle 4", retire); else n_pass++;
    step();
    n_checks++; if (dmem[2] !== 32'd5) $display("FAIL sw_write: mem[2]=%h expected 5", dmem[2]); else n_pass++;
    n_checks++; if (RF_writedata !== 32'd5) $display("FAIL sw_no_rf: RF_writedata=%h expected 5", RF_writedata); else n_pass++;
  endtask

  task automatic test_alu();
    int          cyc;
    logic [31:0] exp_wd [0:8];
    exp_wd = '{32'hFFFFFFFD, 32'h5, 32'h2, 32'hFFFFFFF8, 32'h5, 32'hFFFFFFFD, 32'h1, 32'h0, 32'h2};
    do_reset();
    dmem[0] = 32'hFFFFFFFF;
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFD);
    imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd5);
    imem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    imem[3] = enc_r(5'd1, 5'd2, 5'd4, 6'h22);
    imem[4] = enc_r(5'd1, 5'd2, 5'd5, 6'h24);
    imem[5] = enc_r(5'd1, 5'd2, 5'd6, 6'h25);
    imem[6] = enc_r(5'd1, 5'd2, 5'd7, 6'h2A);
    imem[7] = enc_r(5'd2, 5'd1, 5'd8, 6'h2A);
    imem[8] = enc_r(5'd1, 5'd2, 5'd0, 6'h20);
    imem[9] = enc_i(6'h2B, 5'd0, 5'd0, 16'd0);
    for (int i = 0; i < 9; i++) begin
      wait_retire(cyc);
      n_checks++; if (cyc !== 4) $display("FAIL alu_lat%0d: cycles=%0d expected 4", i, cyc); else n_pass++;
      step();
      n_checks++; if (RF_writedata !== exp_wd[i]) $display("FAIL alu_wd%0d: RF_writedata=%h expected %h", i, RF_writedata, exp_wd[i]); else n_pass++;
    end
    wait_retire(cyc);
    step();
    n_checks++; if (dmem[0] !== 32'h0) $display("FAIL r0_discard: mem[0]=%h expected 0", dmem[0]); else n_pass++;
  endtask

  task automatic test_branch();
    int cyc;
    for (int taken = 1; taken >= 0; taken--) begin
      do_reset();
      imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd7);
      imem[1] = enc_i(6'h08, 5'd0, 5'd2, (taken == 1) ? 16'd7 : 16'd8);
      imem[4] = enc_i(6'h04, 5'd1, 5'd2, 16'hFFFE);
      repeat (2) begin
        wait_retire(cyc);
        step();
      end
      wait_retire(cyc);
      n_checks++; if (cyc !== 2) $display("FAIL nop_latency%0d: cycles=%0d expected 2", taken, cyc); else n_pass++;
      step();
      wait_retire(cyc);
      step();
      n_checks++; if (IR_addr !== 32'h10) $display("FAIL nop_seq%0d: IR_addr=%h expected 10", taken, IR_addr); else n_pass++;
      wait_retire(cyc);
      n_checks++; if (cyc !== 3) $display("FAIL beq_latency%0d: cycles=%0d expected 3", taken, cyc); else n_pass++;
      step();
      n_checks++; if (IR_addr !== ((taken == 1) ? 32'h0C : 32'h14)) $display("FAIL beq_target%0d: IR_addr=%h expected %h", taken, IR_addr, (taken == 1) ? 32'h0C : 32'h14); else n_pass++;
      n_checks++; if (RF_writedata !== 32'h7 + 32'(1 - taken)) $display("FAIL beq_no_rf%0d: RF_writedata=%h expected %h", taken, RF_writedata, 32'h7 + 32'(1 - taken)); else n_pass++;
    end
  endtask

  task automatic test_jumps();
    int cyc;
    do_reset();
    imem[0]  = enc_j(6'h02, 26'h8);
    imem[8]  = enc_j(6'h03, 26'h40);
    imem[64] = enc_r(5'd31, 5'd0, 5'd0, 6'h08);
    wait_retire(cyc);
    n_checks++; if (cyc !== 3) $display("FAIL j_latency: cycles=%0d expected 3", cyc); else n_pass++;
    step();
    n_checks++; if (IR_addr !== 32'h20) $display("FAIL j_target: IR_addr=%h expected 20", IR_addr); else n_pass++;
    wait_retire(cyc);
    n_checks++; if (cyc !== 3) $display("FAIL jal_latency: cycles=%0d expected 3", cyc); else n_pass++;
    step();
    n_checks++; if (IR_addr !== 32'h100 || RF_writedata !== 32'h24) $display("FAIL jal_link: IR_addr=%h WD=%h expected 100 24", IR_addr, RF_writedata); else n_pass++;
    wait_retire(cyc);
    step();
    n_checks++; if (IR_addr !== 32'h24) $display("FAIL jr_target: IR_addr=%h expected 24", IR_addr); else n_pass++;
  endtask

  task automatic test_midop_reset();
    int cyc;
    do_reset();
    wait_cfg = 5;
    dmem[2]  = 32'h1234;
    imem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
    imem[1]  = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
    wait_retire(cyc);
    repeat (5) step();
    n_checks++; if (CEN !== 1'b0 || WEN !== 1'b0) $display("FAIL midop_in_mem: CEN=%b WEN=%b expected 0 0", CEN, WEN); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (CEN !== 1'b1 || WEN !== 1'b1 || retire !== 1'b0) $display("FAIL midop_abort: CEN=%b WEN=%b retire=%b expected 1 1 0", CEN, WEN, retire); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (IR_addr !== 32'h0) $display("FAIL midop_pc: IR_addr=%h expected 0", IR_addr); else n_pass++;
    n_checks++; if (dmem[2] !== 32'h1234) $display("FAIL midop_mem: mem[2]=%h expected 1234", dmem[2]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_wait();
    test_store();
    test_alu();
    test_branch();
    test_jumps();
    test_midop_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
